// File: rtl/bc_branch_resolve_unit_pkg.sv
// bc_branch_resolve_unit_pkg: shared widths, B-form field offsets, BO bit indices and FSM states
package bc_branch_resolve_unit_pkg;
  localparam int ADDR_W = 64;
  localparam int MAJ_W = 64;
  localparam int MIN_W = 7;
  localparam int PID_W = 20;
  localparam int TID_W = 16;
  localparam int REG_W = 5;
  localparam int IMM_W = 14;
  localparam logic [5:0] BC_OPCODE = 6'd16;
  localparam logic [2:0] BRANCH_UNIT_ID = 3'd6;
  // BO[k] in big-endian field numbering lives at vector bit 4-k
  localparam int BO_CR_IGN = 4;
  localparam int BO_CR_VAL = 3;
  localparam int BO_CTR_IGN = 2;
  localparam int BO_CTR_ZERO = 1;
  localparam int BODY_BO_LSB = 21;
  localparam int BODY_BI_LSB = 16;
  localparam int BODY_BD_LSB = 2;
  localparam int BODY_AA = 1;
  localparam int BODY_LK = 0;
  typedef enum logic [1:0] {IDLE, CR_WAIT, RESOLVE} state_e;
  function automatic logic [ADDR_W-1:0] mode_mask(input logic [ADDR_W-1:0] a, input logic is64);
    return is64 ? a : {{(ADDR_W-32){1'b0}}, a[31:0]};
  endfunction
endpackage

// File: rtl/bc_branch_resolve_unit_if.sv
// bc_branch_resolve_unit_if: decode bundle in, resolution out, between dispatch/fetch and the BC unit
interface bc_branch_resolve_unit_if;
  import bc_branch_resolve_unit_pkg::*;
  logic enable;
  logic [5:0] instructionOpcode;
  logic [2:0] functionalUnitType;
  logic [ADDR_W-1:0] instructionAddress;
  logic [MAJ_W-1:0] instMajId;
  logic [MIN_W-1:0] instMinId;
  logic [PID_W-1:0] instPid;
  logic [TID_W-1:0] instTid;
  logic is64Bit;
  logic [25:0] instructionBody;
  logic busy;
  logic resValid;
  logic resTaken;
  logic [ADDR_W-1:0] resTarget;
  logic lrWrite;
  logic [ADDR_W-1:0] lrData;
  logic [MAJ_W-1:0] resMajId;
  logic [MIN_W-1:0] resMinId;
  logic [PID_W-1:0] resPid;
  logic [TID_W-1:0] resTid;
  modport master(
    output enable, instructionOpcode, functionalUnitType, instructionAddress, instMajId, instMinId,
           instPid, instTid, is64Bit, instructionBody,
    input busy, resValid, resTaken, resTarget, lrWrite, lrData, resMajId, resMinId, resPid, resTid
  );
  modport slave(
    input enable, instructionOpcode, functionalUnitType, instructionAddress, instMajId, instMinId,
          instPid, instTid, is64Bit, instructionBody,
    output busy, resValid, resTaken, resTarget, lrWrite, lrData, resMajId, resMinId, resPid, resTid
  );
endinterface

// File: rtl/bc_branch_resolve_unit_condition_eval.sv
// bc_condition_eval: combinational BO/CR/CTR evaluation producing taken and the decremented CTR
module bc_condition_eval
  import bc_branch_resolve_unit_pkg::*;
(
  input  logic [REG_W-1:1] bo_i,
  input  logic             cr_bit_i,
  input  logic [63:0]      ctr_i,
  input  logic             is64_i,
  output logic             taken_o,
  output logic [63:0]      ctr_m_o
);
  logic ctr_zero;
  assign ctr_m_o = bo_i[BO_CTR_IGN] ? ctr_i : ctr_i - 64'd1;
  assign ctr_zero = is64_i ? ctr_m_o == 64'd0 : ctr_m_o[31:0] == 32'd0;
  assign taken_o = (bo_i[BO_CTR_IGN] | (ctr_zero == bo_i[BO_CTR_ZERO])) &
                   (bo_i[BO_CR_IGN] | (cr_bit_i == bo_i[BO_CR_VAL]));
endmodule

// File: rtl/bc_branch_resolve_unit.sv
// bc_branch_resolve_unit: accepts BC bundles, optionally reads one CR bit, resolves and updates CTR/LR
module bc_branch_resolve_unit
  import bc_branch_resolve_unit_pkg::*;
(
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     stall_i,
  bc_branch_resolve_unit_if.slave  bus,
  output logic                     crReadReq_o,
  output logic [REG_W-1:0]         crReadBit_o,
  input  logic                     crReadValid_i,
  input  logic                     crReadData_i,
  input  logic                     ctrWrite_i,
  input  logic [63:0]              ctrWriteData_i,
  output logic [63:0]              ctr_o
);
  state_e state_q;
  logic [REG_W-1:1] bo_q;
  logic [REG_W-1:0] bi_q;
  logic [IMM_W-1:0] bd_q;
  logic aa_q, lk_q, is64_q, cr_bit_q, req_q, res_valid_q, taken_q, lr_we_q;
  logic accept, taken, unused_hint;
  logic [ADDR_W-1:0] cia_q, target_q, lr_data_q, disp, tgt, nia;
  logic [63:0] ctr_q, ctr_m;
  logic [MAJ_W-1:0] maj_q;
  logic [MIN_W-1:0] min_q;
  logic [PID_W-1:0] pid_q;
  logic [TID_W-1:0] tid_q;
  // BO[4] is a prediction hint and never affects resolution
  assign unused_hint = bus.instructionBody[BODY_BO_LSB];
  assign accept = state_q == IDLE && bus.enable && !stall_i &&
                  bus.instructionOpcode == BC_OPCODE && bus.functionalUnitType == BRANCH_UNIT_ID;
  assign disp = {{(ADDR_W-IMM_W-2){bd_q[IMM_W-1]}}, bd_q, 2'b00};
  assign nia = mode_mask(cia_q + ADDR_W'(4), is64_q);
  assign tgt = mode_mask(aa_q ? disp : cia_q + disp, is64_q);
  bc_condition_eval u_eval (
    .bo_i(bo_q),
    .cr_bit_i(cr_bit_q),
    .ctr_i(ctr_q),
    .is64_i(is64_q),
    .taken_o(taken),
    .ctr_m_o(ctr_m)
  );
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      bo_q <= '0;
      bi_q <= '0;
      bd_q <= '0;
      aa_q <= 1'b0;
      lk_q <= 1'b0;
      is64_q <= 1'b0;
      cia_q <= '0;
      maj_q <= '0;
      min_q <= '0;
      pid_q <= '0;
      tid_q <= '0;
      cr_bit_q <= 1'b0;
      req_q <= 1'b0;
      res_valid_q <= 1'b0;
      taken_q <= 1'b0;
      target_q <= '0;
      lr_we_q <= 1'b0;
      lr_data_q <= '0;
      ctr_q <= '0;
    end else begin
      if (ctrWrite_i)
        ctr_q <= ctrWriteData_i;
      else if (state_q == RESOLVE && !stall_i && !bo_q[BO_CTR_IGN])
        ctr_q <= ctr_m;
      // the CR response is taken even under stall so the responder never has to repeat it
      if (state_q == CR_WAIT && req_q && crReadValid_i) begin
        cr_bit_q <= crReadData_i;
        req_q <= 1'b0;
      end
      if (!stall_i) begin
        res_valid_q <= state_q == RESOLVE;
        lr_we_q <= state_q == RESOLVE && lk_q;
        if (accept) begin
          bo_q <= bus.instructionBody[BODY_BO_LSB+REG_W-1 -: REG_W-1];
          bi_q <= bus.instructionBody[BODY_BI_LSB +: REG_W];
          bd_q <= bus.instructionBody[BODY_BD_LSB +: IMM_W];
          aa_q <= bus.instructionBody[BODY_AA];
          lk_q <= bus.instructionBody[BODY_LK];
          is64_q <= bus.is64Bit;
          cia_q <= bus.instructionAddress;
          maj_q <= bus.instMajId;
          min_q <= bus.instMinId;
          pid_q <= bus.instPid;
          tid_q <= bus.instTid;
          req_q <= !bus.instructionBody[BODY_BO_LSB+BO_CR_IGN];
          state_q <= bus.instructionBody[BODY_BO_LSB+BO_CR_IGN] ? RESOLVE : CR_WAIT;
        end else if (state_q == CR_WAIT && (crReadValid_i || !req_q)) begin
          state_q <= RESOLVE;
        end else if (state_q == RESOLVE) begin
          taken_q <= taken;
          target_q <= taken ? tgt : nia;
          lr_data_q <= nia;
          state_q <= IDLE;
        end
      end
    end
  end
  assign crReadReq_o = req_q;
  assign crReadBit_o = bi_q;
  assign ctr_o = ctr_q;
  assign bus.busy = state_q != IDLE;
  assign bus.resValid = res_valid_q;
  assign bus.resTaken = taken_q;
  assign bus.resTarget = target_q;
  assign bus.lrWrite = lr_we_q;
  assign bus.lrData = lr_data_q;
  assign bus.resMajId = maj_q;
  assign bus.resMinId = min_q;
  assign bus.resPid = pid_q;
  assign bus.resTid = tid_q;
endmodule

// File: tb/tb_bc_branch_resolve_unit.sv
// tb_bc_branch_resolve_unit: directed vector table plus hand sequences for CR wait, stall and reset
module tb_bc_branch_resolve_unit;
  import bc_branch_resolve_unit_pkg::*;
  typedef struct {
    logic [4:0] bo;
    logic [4:0] bi;
    logic [13:0] bd;
    logic aa;
    logic lk;
    logic is64;
    logic [63:0] cia;
    logic [63:0] ctr;
    logic cr;
    int d;
    logic taken;
    logic [63:0] tgt;
    logic [63:0] ctr_e;
    logic [63:0] lr;
  } vec_t;
  logic clk = 1'b0;
  logic reset_i, stall_i, crReadValid_i, crReadData_i, ctrWrite_i, crReadReq_o;
  logic [4:0] crReadBit_o;
  logic [63:0] ctrWriteData_i, ctr_o;
  int total = 0;
  int passed = 0;
  int tag_n = 0;
  string cur = "init";
  vec_t vecs[13];
  bc_branch_resolve_unit_if bus();
  bc_branch_resolve_unit dut (
    .clock_i(clk),
    .reset_i(reset_i),
    .stall_i(stall_i),
    .bus(bus),
    .crReadReq_o(crReadReq_o),
    .crReadBit_o(crReadBit_o),
    .crReadValid_i(crReadValid_i),
    .crReadData_i(crReadData_i),
    .ctrWrite_i(ctrWrite_i),
    .ctrWriteData_i(ctrWriteData_i),
    .ctr_o(ctr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s %s: got %h expected %h", cur, nm, act, exp);
  endtask
  task automatic send(input logic [4:0] bo, input logic [4:0] bi, input logic [13:0] bd,
                      input logic aa, input logic lk, input logic [63:0] cia, input logic is64);
    tag_n++;
    bus.enable = 1'b1;
    bus.instructionOpcode = 6'd16;
    bus.functionalUnitType = 3'd6;
    bus.instructionAddress = cia;
    bus.instructionBody = {bo, bi, bd, aa, lk};
    bus.is64Bit = is64;
    bus.instMajId = 64'hABCD_0000_0000_0000 | 64'(tag_n);
    bus.instMinId = 7'(tag_n);
    bus.instPid = 20'(tag_n * 3);
    bus.instTid = 16'(tag_n * 5);
    @(negedge clk);
    bus.enable = 1'b0;
  endtask
  task automatic set_ctr(input logic [63:0] v);
    ctrWrite_i = 1'b1;
    ctrWriteData_i = v;
    @(negedge clk);
    ctrWrite_i = 1'b0;
  endtask
  task automatic wait_res(output int k);
    k = 0;
    while (!bus.resValid && k < 8) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic run_vec(input vec_t v);
    int k;
    set_ctr(v.ctr);
    send(v.bo, v.bi, v.bd, v.aa, v.lk, v.cia, v.is64);
    chk("busy", 64'(bus.busy), 64'd1);
    if (!v.bo[4]) begin
      for (int i = 0; i < v.d; i++) begin
        chk("cr_req", 64'(crReadReq_o), 64'd1);
        chk("cr_bit", 64'(crReadBit_o), 64'(v.bi));
        if (i == v.d - 1) begin
          crReadValid_i = 1'b1;
          crReadData_i = v.cr;
        end
        @(negedge clk);
      end
      crReadValid_i = 1'b0;
      chk("cr_drop", 64'(crReadReq_o), 64'd0);
    end else begin
      chk("no_cr_req", 64'(crReadReq_o), 64'd0);
    end
    wait_res(k);
    chk("latency", 64'(k), 64'd1);
    chk("taken", 64'(bus.resTaken), 64'(v.taken));
    chk("target", bus.resTarget, v.tgt);
    chk("ctr", ctr_o, v.ctr_e);
    chk("lr_we", 64'(bus.lrWrite), 64'(v.lk));
    if (v.lk) chk("lr_data", bus.lrData, v.lr);
    chk("maj", bus.resMajId, 64'hABCD_0000_0000_0000 | 64'(tag_n));
    chk("min", 64'(bus.resMinId), 64'(7'(tag_n)));
    chk("pid", 64'(bus.resPid), 64'(20'(tag_n * 3)));
    chk("tid", 64'(bus.resTid), 64'(16'(tag_n * 5)));
    @(negedge clk);
    chk("valid_drop", 64'(bus.resValid), 64'd0);
    chk("lr_we_drop", 64'(bus.lrWrite), 64'd0);
  endtask
  initial begin
    int k, cnt;
    vecs[0]  = '{5'b10100, 5'd0, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd7,          1'b0, 0, 1'b1, 64'h1010,                64'd7,                  64'h0};
    vecs[1]  = '{5'b01100, 5'd3, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd7,          1'b1, 3, 1'b1, 64'h1010,                64'd7,                  64'h0};
    vecs[2]  = '{5'b01100, 5'd3, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd7,          1'b0, 3, 1'b0, 64'h1004,                64'd7,                  64'h0};
    vecs[3]  = '{5'b10010, 5'd0, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd1,          1'b0, 0, 1'b1, 64'h1010,                64'd0,                  64'h0};
    vecs[4]  = '{5'b10010, 5'd0, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd0,          1'b0, 0, 1'b0, 64'h1004,                64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[5]  = '{5'b10010, 5'd0, 14'd1,      1'b0, 1'b0, 1'b0, 64'hFFFF_FFFC, 64'h1_0000_0001, 1'b0, 0, 1'b1, 64'h0,                   64'h1_0000_0000,        64'h0};
    vecs[6]  = '{5'b10100, 5'd0, 14'h3FFF,   1'b1, 1'b1, 1'b1, 64'h2000,      64'd7,          1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7,                  64'h2004};
    vecs[7]  = '{5'b00100, 5'd9, 14'd4,      1'b0, 1'b1, 1'b1, 64'h2000,      64'd7,          1'b1, 1, 1'b0, 64'h2004,                64'd7,                  64'h2004};
    vecs[8]  = '{5'b00000, 5'd2, 14'h3FFE,   1'b0, 1'b0, 1'b1, 64'h1000,      64'd5,          1'b0, 2, 1'b1, 64'h0FF8,                64'd4,                  64'h0};
    vecs[9]  = '{5'b10100, 5'd0, 14'h2000,   1'b1, 1'b0, 1'b0, 64'h1000,      64'd7,          1'b0, 0, 1'b1, 64'hFFFF_8000,           64'd7,                  64'h0};
    vecs[10] = '{5'b10101, 5'd0, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'd7,          1'b0, 0, 1'b1, 64'h1010,                64'd7,                  64'h0};
    vecs[11] = '{5'b10010, 5'd0, 14'd4,      1'b0, 1'b0, 1'b1, 64'h1000,      64'h1_0000_0001, 1'b0, 0, 1'b0, 64'h1004,                64'h1_0000_0000,        64'h0};
    vecs[12] = '{5'b10010, 5'd0, 14'd4,      1'b0, 1'b0, 1'b0, 64'h1000,      64'h5_0000_0000, 1'b0, 0, 1'b0, 64'h1004,                64'h4_FFFF_FFFF,        64'h0};
    reset_i = 1'b1;
    stall_i = 1'b0;
    crReadValid_i = 1'b0;
    crReadData_i = 1'b0;
    ctrWrite_i = 1'b0;
    ctrWriteData_i = '0;
    bus.enable = 1'b0;
    bus.instructionOpcode = '0;
    bus.functionalUnitType = '0;
    bus.instructionAddress = '0;
    bus.instMajId = '0;
    bus.instMinId = '0;
    bus.instPid = '0;
    bus.instTid = '0;
    bus.is64Bit = 1'b1;
    bus.instructionBody = '0;
    repeat (3) @(negedge clk);
    cur = "reset";
    chk("busy", 64'(bus.busy), 64'd0);
    chk("cr_req", 64'(crReadReq_o), 64'd0);
    chk("res_valid", 64'(bus.resValid), 64'd0);
    chk("ctr", ctr_o, 64'd0);
    chk("target", bus.resTarget, 64'd0);
    reset_i = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      cur = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end
    cur = "ignore_opcode";
    bus.enable = 1'b1;
    bus.instructionOpcode = 6'd18;
    bus.functionalUnitType = 3'd6;
    bus.instructionBody = {5'b00100, 5'd1, 14'd4, 2'b00};
    @(negedge clk);
    chk("busy", 64'(bus.busy), 64'd0);
    chk("cr_req", 64'(crReadReq_o), 64'd0);
    cur = "ignore_fu";
    bus.instructionOpcode = 6'd16;
    bus.functionalUnitType = 3'd5;
    @(negedge clk);
    bus.enable = 1'b0;
    chk("busy", 64'(bus.busy), 64'd0);
    chk("cr_req", 64'(crReadReq_o), 64'd0);
    cur = "ctr_write_wins";
    set_ctr(64'd9);
    send(5'b10010, 5'd0, 14'd4, 1'b0, 1'b0, 64'h1000, 1'b1);
    ctrWrite_i = 1'b1;
    ctrWriteData_i = 64'h55;
    @(negedge clk);
    ctrWrite_i = 1'b0;
    chk("res_valid", 64'(bus.resValid), 64'd1);
    chk("ctr", ctr_o, 64'h55);
    chk("taken", 64'(bus.resTaken), 64'd0);
    @(negedge clk);
    cur = "stall_resolve";
    send(5'b10100, 5'd0, 14'd4, 1'b0, 1'b0, 64'h3000, 1'b1);
    stall_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("busy_held", 64'(bus.busy), 64'd1);
      chk("valid_held", 64'(bus.resValid), 64'd0);
    end
    stall_i = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(bus.resValid);
    end
    chk("one_resolution", 64'(cnt), 64'd1);
    cur = "stall_hold_output";
    send(5'b10100, 5'd0, 14'd4, 1'b0, 1'b0, 64'h3000, 1'b1);
    @(negedge clk);
    chk("res_valid", 64'(bus.resValid), 64'd1);
    stall_i = 1'b1;
    @(negedge clk);
    chk("valid_held", 64'(bus.resValid), 64'd1);
    chk("target_held", bus.resTarget, 64'h3010);
    stall_i = 1'b0;
    @(negedge clk);
    chk("valid_drop", 64'(bus.resValid), 64'd0);
    cur = "cr_while_stalled";
    send(5'b01100, 5'd3, 14'd4, 1'b0, 1'b0, 64'h1000, 1'b1);
    stall_i = 1'b1;
    crReadValid_i = 1'b1;
    crReadData_i = 1'b1;
    @(negedge clk);
    crReadValid_i = 1'b0;
    crReadData_i = 1'b0;
    chk("cr_drop", 64'(crReadReq_o), 64'd0);
    chk("busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("valid_held", 64'(bus.resValid), 64'd0);
    stall_i = 1'b0;
    wait_res(k);
    chk("latency", 64'(k), 64'd2);
    chk("taken", 64'(bus.resTaken), 64'd1);
    chk("target", bus.resTarget, 64'h1010);
    @(negedge clk);
    cur = "reset_in_cr_wait";
    set_ctr(64'h77);
    send(5'b00100, 5'd7, 14'd4, 1'b0, 1'b1, 64'h1000, 1'b1);
    chk("cr_req", 64'(crReadReq_o), 64'd1);
    chk("cr_bit", 64'(crReadBit_o), 64'd7);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("cr_req", 64'(crReadReq_o), 64'd0);
    chk("busy", 64'(bus.busy), 64'd0);
    chk("ctr", ctr_o, 64'd0);
    crReadValid_i = 1'b1;
    crReadData_i = 1'b0;
    @(negedge clk);
    crReadValid_i = 1'b0;
    cnt = int'(bus.resValid);
    repeat (4) begin
      @(negedge clk);
      cnt += int'(bus.resValid);
    end
    chk("no_resolution", 64'(cnt), 64'd0);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
